// File: rtl/bcd_converter_pkg.sv
// Shared constants and types for the multicycle binary-to-BCD converter.
package bcd_converter_pkg;

  localparam int unsigned WIDTH_DEF  = 16;
  localparam int unsigned DIGITS_DEF = 5;

  // Double-dabble digit correction: nibbles at or above the threshold get the addend.
  localparam logic [3:0] ADD3_THRESHOLD = 4'd5;
  localparam logic [3:0] ADD3_ADDEND    = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Per-digit double-dabble correction: add 3 to a nibble of 5 or more.
module bcd_add3
  import bcd_converter_pkg::*;
(
  input  logic [3:0] raw,
  output logic [3:0] corrected_c
);

  // Inputs are 0..9 during conversion, so the sum never exceeds 12.
  assign corrected_c = (raw >= ADD3_THRESHOLD) ? raw + ADD3_ADDEND : raw;

endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter: one double-dabble iteration per clock,
// result held in a registered digit bank for the display drivers.
module bcd_converter
  import bcd_converter_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     bin_q;
  logic [BCD_W-1:0]     scratch;
  logic [BCD_W-1:0]     adjusted;
  logic [CNT_W-1:0]     cnt;
  logic [BCD_W+WIDTH-1:0] shifted;
  logic                 last_iter;

  // Correct every scratch digit before the shift.
  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    bcd_add3 u_add3 (
      .raw         (scratch[4*d +: 4]),
      .corrected_c (adjusted[4*d +: 4])
    );
  end

  assign shifted   = {adjusted, bin_q} << 1;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      ST_SHIFT: if (last_iter) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      state   <= ST_IDLE;
      bin_q   <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd     <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != ST_IDLE);
      valid <= (state_next == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            bin_q   <= bin;
            scratch <= '0;
            cnt     <= '0;
          end
        end
        ST_SHIFT: begin
          scratch <= shifted[WIDTH +: BCD_W];
          bin_q   <= shifted[WIDTH-1:0];
          cnt     <= cnt + CNT_W'(1);
          // Final iteration publishes the freshly shifted digits.
          if (last_iter) bcd <= shifted[WIDTH +: BCD_W];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_converter.sv
// Self-checking bench for bcd_converter: vector table, corner sequences and
// randomized values against an arithmetic decimal-digit model.
module tb_bcd_converter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        valid;
  logic [19:0] bcd;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_converter dut (
    .clock  (clk),
    .resetn (resetn),
    .start  (start),
    .bin    (bin),
    .busy   (busy),
    .valid  (valid),
    .bcd    (bcd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    logic [19:0] expected;
  } vec_t;

  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept v, optionally inject dropped start pulses after samples drop1/drop2,
  // then watch 40 cycles for busy length, valid count/position and result.
  task automatic run_conv(input logic [15:0] v, input logic [19:0] exp,
                          input int drop1, input int drop2, input string tag);
    int busy_cnt;
    int valid_cnt;
    int valid_at;
    logic [19:0] got;
    start = 1'b1;
    bin   = v;
    tick();
    busy_cnt  = busy ? 1 : 0;
    valid_cnt = 0;
    valid_at  = -1;
    got       = '0;
    for (int k = 1; k <= 40; k++) begin
      if (k - 1 == drop1 || k - 1 == drop2) begin
        start = 1'b1;
        bin   = 16'd9;
      end else begin
        start = 1'b0;
        bin   = 16'($urandom);
      end
      tick();
      if (busy) busy_cnt++;
      if (valid) begin
        valid_cnt++;
        valid_at = k;
        got      = bcd;
      end
    end
    start = 1'b0;
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd17);
    check({tag, " valid_count"}, 32'(valid_cnt), 32'd1);
    check({tag, " valid_latency"}, 32'(valid_at), 32'd16);
    check({tag, " result"}, 32'(got), 32'(exp));
  endtask

  vec_t vecs[8];
  logic [15:0] held_bins[100];

  initial begin
    vecs[0] = '{16'd0,     20'h00000};
    vecs[1] = '{16'd1234,  20'h01234};
    vecs[2] = '{16'd65535, 20'h65535};
    vecs[3] = '{16'd10,    20'h00010};
    vecs[4] = '{16'd9999,  20'h09999};
    vecs[5] = '{16'd1,     20'h00001};
    vecs[6] = '{16'd59999, 20'h59999};
    vecs[7] = '{16'd777,   20'h00777};

    // Reset with start asserted: reset must win.
    resetn = 1'b1;
    start  = 1'b1;
    bin    = 16'd123;
    repeat (3) tick();
    start  = 1'b0;
    resetn = 1'b0;
    tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset bcd", 32'(bcd), 32'd0);

    // Table vectors; the last one (777) leaves bcd for the stability check.
    for (int i = 0; i < 8; i++)
      run_conv(vecs[i].value, vecs[i].expected, -1, -1, $sformatf("vec%0d", i));

    // bcd must hold and valid stay low while idle with bin toggling.
    begin
      int bad_hold;
      bad_hold = 0;
      for (int k = 0; k < 50; k++) begin
        bin = 16'($urandom);
        tick();
        check("hold bcd", 32'(bcd), 32'h00777);
        check("hold valid", 32'(valid), 32'd0);
      end
    end

    // start pulses during SHIFT and DONE are dropped.
    run_conv(16'd500, 20'h00500, 3, 16, "drop");

    // Reset mid-conversion of 999.
    begin
      int valid_seen;
      valid_seen = 0;
      start = 1'b1;
      bin   = 16'd999;
      tick();
      start = 1'b0;
      repeat (7) tick();
      resetn = 1'b1;
      tick();
      resetn = 1'b0;
      check("abort busy", 32'(busy), 32'd0);
      check("abort bcd", 32'(bcd), 32'd0);
      check("abort valid", 32'(valid), 32'd0);
      for (int k = 0; k < 20; k++) begin
        tick();
        if (valid) valid_seen++;
      end
      check("abort no valid", 32'(valid_seen), 32'd0);
    end
    run_conv(16'd42, 20'h00042, -1, -1, "after_abort");

    // start held high with bin changing every cycle.
    begin
      int n_valid;
      n_valid = 0;
      start = 1'b1;
      for (int e = 0; e < 100; e++) begin
        bin = 16'($urandom);
        held_bins[e] = bin;
        tick();
        if (valid) begin
          n_valid++;
          check("stream valid position", 32'((e - 16) % 18), 32'd0);
          if (e >= 16)
            check("stream result", 32'(bcd), 32'(to_bcd(32'(held_bins[e - 16]))));
        end
      end
      start = 1'b0;
      check("stream valid count", 32'(n_valid), 32'd5);
      begin
        int w;
        w = 0;
        while (busy && w < 30) begin
          tick();
          w++;
        end
        check("stream drain", 32'(busy), 32'd0);
      end
    end

    // Randomized values against the decimal model.
    for (int i = 0; i < 20; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      run_conv(r, to_bcd(32'(r)), -1, -1, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
